// File: rtl/snax_cgra_csr_responder.sv
// rtl/snax_cgra_csr_responder.sv - CSR responder for the CGRA: config bank, launch control, status and busy counter
// Optional build macro SNAX_CGRA_CSR_PERF_EN adds the busy-cycle counter at word address NumCfgRegs+2.

module snax_cgra_csr_responder #(
    parameter int unsigned NumCfgRegs = 8,
    parameter int unsigned CntWidth   = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [63:0]              io_csr_req_bits_data_i,
    input  logic [31:0]              io_csr_req_bits_addr_i,
    input  logic                     io_csr_req_bits_write_i,
    input  logic                     io_csr_req_valid_i,
    output logic                     io_csr_req_ready_o,
    input  logic                     io_csr_rsp_ready_i,
    output logic                     io_csr_rsp_valid_o,
    output logic [63:0]              io_csr_rsp_bits_data_o,
    output logic [64*NumCfgRegs-1:0] cfg_regs_o,
    output logic                     cgra_start_o,
    input  logic                     cgra_done_i
);

    localparam logic [31:0] AddrCtrl   = 32'(NumCfgRegs);
    localparam logic [31:0] AddrStatus = 32'(NumCfgRegs + 1);
    localparam logic [31:0] AddrPerf   = 32'(NumCfgRegs + 2);

    typedef enum logic {
        IDLE,
        RSP
    } state_e;

    state_e      state_q;
    logic [63:0] cfg_q [NumCfgRegs];
    logic        busy_q;
    logic        done_sticky_q;
    logic        rsp_valid_q;
    logic [63:0] rsp_data_q;
    logic        start_q;

    logic        is_cfg;
    logic        is_ctrl;
    logic        stall;
    logic        req_hs;
    logic        wr_hs;
    logic        rd_hs;
    logic        start_req;
    logic [63:0] rd_data;
    logic [63:0] perf_val;

    assign is_cfg  = io_csr_req_bits_addr_i < AddrCtrl;
    assign is_ctrl = io_csr_req_bits_addr_i == AddrCtrl;

    // Config and launch writes are held off while the fabric is running.
    assign stall = busy_q && io_csr_req_bits_write_i && (is_cfg || is_ctrl);

    assign io_csr_req_ready_o = (state_q == IDLE) && !stall;
    assign req_hs    = io_csr_req_valid_i && io_csr_req_ready_o;
    assign wr_hs     = req_hs && io_csr_req_bits_write_i;
    assign rd_hs     = req_hs && !io_csr_req_bits_write_i;
    assign start_req = wr_hs && is_ctrl && io_csr_req_bits_data_i[0] && !busy_q;

`ifdef SNAX_CGRA_CSR_PERF_EN
    logic [CntWidth-1:0] perf_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt_q <= '0;
        end else if (start_req) begin
            perf_cnt_q <= '0;
        end else if (busy_q && !(&perf_cnt_q)) begin
            perf_cnt_q <= perf_cnt_q + 1'b1;
        end
    end

    assign perf_val = 64'(perf_cnt_q);
`else
    assign perf_val = 64'd0;
`endif

    always_comb begin
        rd_data = 64'd0;
        for (int unsigned k = 0; k < NumCfgRegs; k++) begin
            if (io_csr_req_bits_addr_i == 32'(k)) begin
                rd_data = cfg_q[k];
            end
        end
        if (io_csr_req_bits_addr_i == AddrStatus) begin
            rd_data = {62'd0, done_sticky_q, busy_q};
        end else if (io_csr_req_bits_addr_i == AddrPerf) begin
            rd_data = perf_val;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NumCfgRegs; k++) begin
                cfg_q[k] <= 64'd0;
            end
        end else begin
            for (int unsigned k = 0; k < NumCfgRegs; k++) begin
                if (wr_hs && io_csr_req_bits_addr_i == 32'(k)) begin
                    cfg_q[k] <= io_csr_req_bits_data_i;
                end
            end
        end
    end

    for (genvar g = 0; g < NumCfgRegs; g++) begin : gen_cfg_out
        assign cfg_regs_o[64*g +: 64] = cfg_q[g];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 64'd0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_sticky_q <= 1'b0;
        end else begin
            start_q <= start_req;

            // Start needs busy low, so it can never collide with a done.
            if (start_req) begin
                busy_q        <= 1'b1;
                done_sticky_q <= 1'b0;
            end else if (cgra_done_i && busy_q) begin
                busy_q        <= 1'b0;
                done_sticky_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (rd_hs) begin
                        rsp_data_q  <= rd_data;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (io_csr_rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign io_csr_rsp_valid_o     = rsp_valid_q;
    assign io_csr_rsp_bits_data_o = rsp_data_q;
    assign cgra_start_o           = start_q;

endmodule

// File: tb/tb_snax_cgra_csr_responder.sv
// tb/tb_snax_cgra_csr_responder.sv - directed self-checking bench for snax_cgra_csr_responder

module tb_snax_cgra_csr_responder;

    localparam int unsigned NumCfgRegs = 8;
    localparam logic [31:0] ACtrl      = 32'd8;
    localparam logic [31:0] AStatus    = 32'd9;
    localparam logic [31:0] APerf      = 32'd10;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic [63:0]              req_data = '0;
    logic [31:0]              req_addr = '0;
    logic                     req_write = 1'b0;
    logic                     req_valid = 1'b0;
    logic                     req_ready;
    logic                     rsp_ready = 1'b0;
    logic                     rsp_valid;
    logic [63:0]              rsp_data;
    logic [64*NumCfgRegs-1:0] cfg_regs;
    logic                     cgra_start;
    logic                     cgra_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    snax_cgra_csr_responder #(.NumCfgRegs(NumCfgRegs), .CntWidth(32)) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .io_csr_req_bits_data_i (req_data),
        .io_csr_req_bits_addr_i (req_addr),
        .io_csr_req_bits_write_i(req_write),
        .io_csr_req_valid_i     (req_valid),
        .io_csr_req_ready_o     (req_ready),
        .io_csr_rsp_ready_i     (rsp_ready),
        .io_csr_rsp_valid_o     (rsp_valid),
        .io_csr_rsp_bits_data_o (rsp_data),
        .cfg_regs_o             (cfg_regs),
        .cgra_start_o           (cgra_start),
        .cgra_done_i            (cgra_done)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (cgra_start) start_cnt++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d);
        logic ok;
        ok = 1'b0;
        @(negedge clk_i);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_data = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            else @(negedge clk_i);
        end
        check_eq("wr_accept", {63'd0, ok}, 64'd1);
        if (ok) begin
            @(posedge clk_i);
            #1;
        end
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [63:0] d);
        logic ok;
        ok = 1'b0;
        d  = '0;
        @(negedge clk_i);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            else @(negedge clk_i);
        end
        check_eq("rd_accept", {63'd0, ok}, 64'd1);
        if (ok) begin
            @(posedge clk_i);
            #1;
            req_valid = 1'b0;
            check_eq("rd_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            d = rsp_data;
            rsp_ready = 1'b1;
            @(posedge clk_i);
            #1;
            rsp_ready = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] rd;
        logic [64*NumCfgRegs-1:0] snap;
        int s0;

        #12;
        check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("rst_rsp_data", rsp_data, 64'd0);
        check_eq("rst_start", {63'd0, cgra_start}, 64'd0);
        check_eq("rst_cfg_zero", {63'd0, |cfg_regs}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_eq("idle_req_ready", {63'd0, req_ready}, 64'd1);

        // Test 1: CFG write/read
        do_write(32'd3, 64'hDEAD_BEEF_0123_4567);
        check_eq("cfg3_out", cfg_regs[255:192], 64'hDEAD_BEEF_0123_4567);
        do_read(32'd3, rd);
        check_eq("cfg3_read", rd, 64'hDEAD_BEEF_0123_4567);

        // Test 2: response back-pressure
        do_write(32'd0, 64'h1111_2222_3333_4444);
        @(negedge clk_i);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd0;
        check_eq("t2_ready_before", {63'd0, req_ready}, 64'd1);
        @(posedge clk_i);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_eq("t2_hold_valid", {63'd0, rsp_valid}, 64'd1);
            check_eq("t2_hold_data", rsp_data, 64'h1111_2222_3333_4444);
            check_eq("t2_hold_req_ready", {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready = 1'b0;
        check_eq("t2_valid_drop", {63'd0, rsp_valid}, 64'd0);
        check_eq("t2_req_ready_back", {63'd0, req_ready}, 64'd1);

        // Done while idle is ignored
        @(negedge clk_i); cgra_done = 1'b1;
        @(negedge clk_i); cgra_done = 1'b0;
        do_read(AStatus, rd);
        check_eq("status_idle", rd, 64'h0);

        // Test 3: start, stall, done
        s0 = start_cnt;
        do_write(ACtrl, 64'h1);
        repeat (3) @(negedge clk_i);
        check_eq("start_pulses", 64'(start_cnt - s0), 64'd1);
        do_read(AStatus, rd);
        check_eq("status_busy", rd, 64'h1);
        do_read(ACtrl, rd);
        check_eq("ctrl_read_zero", rd, 64'h0);
        @(negedge clk_i);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd1; req_data = 64'hCAFE_0000_0000_0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check_eq("t3_stall", {63'd0, req_ready}, 64'd0);
        end
        check_eq("t3_cfg1_unchanged", cfg_regs[127:64], 64'd0);
        cgra_done = 1'b1;
        @(negedge clk_i);
        cgra_done = 1'b0;
        check_eq("t3_unstall", {63'd0, req_ready}, 64'd1);
        @(posedge clk_i);
        #1;
        req_valid = 1'b0; req_write = 1'b0;
        check_eq("t3_cfg1_written", cfg_regs[127:64], 64'hCAFE_0000_0000_0001);
        do_read(AStatus, rd);
        check_eq("status_done", rd, 64'h2);

        // Test 4: busy-cycle counter over exactly 10 busy cycles
        do_write(ACtrl, 64'h1);
        repeat (9) @(posedge clk_i);
        #1;
        cgra_done = 1'b1;
        @(posedge clk_i);
        #1;
        cgra_done = 1'b0;
        do_read(APerf, rd);
`ifdef SNAX_CGRA_CSR_PERF_EN
        check_eq("perf_count", rd, 64'd10);
`else
        check_eq("perf_count", rd, 64'd0);
`endif
        do_read(AStatus, rd);
        check_eq("status_done2", rd, 64'h2);

        // CTRL write with bit0 = 0 does nothing
        s0 = start_cnt;
        do_write(ACtrl, 64'h2);
        repeat (2) @(negedge clk_i);
        check_eq("ctrl_bit0_zero", 64'(start_cnt - s0), 64'd0);

        // Test 5: unmapped address
        do_read(32'd200, rd);
        check_eq("unmapped_read", rd, 64'd0);
        snap = cfg_regs;
        do_write(32'd200, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("unmapped_no_change", {63'd0, cfg_regs != snap}, 64'd0);
        @(negedge clk_i);
        check_eq("unmapped_no_rsp", {63'd0, rsp_valid}, 64'd0);

        // Test 6: reset while in RSP with busy set
        do_write(32'd5, 64'h5555_AAAA_5555_AAAA);
        do_write(ACtrl, 64'h1);
        @(negedge clk_i);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd5;
        @(posedge clk_i);
        #1;
        req_valid = 1'b0;
        check_eq("t6_in_rsp", {63'd0, rsp_valid}, 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_eq("t6_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check_eq("t6_rst_rsp_data", rsp_data, 64'd0);
        check_eq("t6_rst_cfg", {63'd0, |cfg_regs}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        do_read(AStatus, rd);
        check_eq("t6_status_after", rd, 64'h0);
        do_write(32'd7, 64'h0123_4567_89AB_CDEF);
        do_read(32'd7, rd);
        check_eq("t6_cfg7_read", rd, 64'h0123_4567_89AB_CDEF);
        check_eq("t6_cfg7_out", cfg_regs[511:448], 64'h0123_4567_89AB_CDEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
